pixel_fetch: RTL and testbench

Fetches 2-bit-per-pixel image data from a synchronous byte-wide framebuffer memory and produces a per-pixel colour index aligned with the display timing signals. It sits between the display timing generator and the `palette` stage, and drives `palette`'s colour index input. It also carries DE/HSYNC/VSYNC through a matching delay, so RGB and sync reach the panel together.

---
 rtl/pixel_fetch.sv | 141 ++++++++++++++
 tb/tb_pixel_fetch.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pixel_fetch.sv
// Fetches 2bpp pixels from a byte-wide synchronous framebuffer and emits a colour index
// aligned (2-cycle latency) with delayed DE/HSYNC/VSYNC.
module pixel_fetch #(
  parameter int          IMG_W      = 160,
  parameter int          IMG_H      = 144,
  parameter int          X_OFF      = 160,
  parameter int          Y_OFF      = 64,
  parameter int          SCALE_LOG2 = 0,
  parameter logic [1:0]  BG_COLOR   = 2'b00,
  parameter int          ADDR_W     = 13
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_de,
  input  logic              i_hsync,
  input  logic              i_vsync,
  input  logic [10:0]       i_x,
  input  logic [10:0]       i_y,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_rd_en,
  input  logic [7:0]        i_rdata,
  output logic [1:0]        o_color,
  output logic              o_de,
  output logic              o_hsync,
  output logic              o_vsync
);

  localparam int         BYTES_PER_ROW = IMG_W / 4;
  localparam logic [11:0] X_LO     = 12'(X_OFF);
  localparam logic [11:0] X_HI     = 12'(X_OFF + (IMG_W << SCALE_LOG2));
  localparam logic [11:0] Y_LO     = 12'(Y_OFF);
  localparam logic [11:0] Y_HI     = 12'(Y_OFF + (IMG_H << SCALE_LOG2));
  localparam logic [1:0]  VREP_MAX = 2'((1 << SCALE_LOG2) - 1);

  logic              x_hit;
  logic              y_above;
  logic              y_hit;
  logic              in_win;
  logic              de_fall;
  logic [10:0]       x_rel;
  logic [10:0]       px;
  logic [ADDR_W-1:0] byte_col;
  logic [ADDR_W-1:0] row_base;
  logic [1:0]        vrep;

  logic              de_s1;
  logic              hsync_s1;
  logic              vsync_s1;
  logic              win_s1;
  logic [1:0]        sel_s1;
  logic              win_s2;
  logic [1:0]        sel_s2;
  logic [1:0]        field;

  // With the window starting at line 0 there is no region above it to resync in.
  if (Y_OFF == 0) begin : g_no_above
    assign y_above = 1'b0;
  end else begin : g_above
    assign y_above = ({1'b0, i_y} < Y_LO);
  end

  always_comb begin
    x_hit    = ({1'b0, i_x} >= X_LO) && ({1'b0, i_x} < X_HI);
    y_hit    = !y_above && ({1'b0, i_y} < Y_HI);
    in_win   = i_de && x_hit && y_hit;
    x_rel    = i_x - X_LO[10:0];
    px       = x_rel >> SCALE_LOG2;
    byte_col = ADDR_W'(px >> 2);
    de_fall  = de_s1 && !i_de;
  end

  // Row tracking: one source row per 2^SCALE_LOG2 display lines.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      row_base <= '0;
      vrep     <= '0;
    end else if (y_above) begin
      row_base <= '0;
      vrep     <= '0;
    end else if (de_fall && y_hit) begin
      if (vrep == VREP_MAX) begin
        vrep     <= '0;
        row_base <= row_base + ADDR_W'(BYTES_PER_ROW);
      end else begin
        vrep <= vrep + 2'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_addr   <= '0;
      o_rd_en  <= 1'b0;
      win_s1   <= 1'b0;
      sel_s1   <= 2'b00;
      de_s1    <= 1'b0;
      hsync_s1 <= 1'b1;
      vsync_s1 <= 1'b1;
    end else begin
      o_rd_en  <= in_win;
      if (in_win) begin
        o_addr <= row_base + byte_col;
      end
      win_s1   <= in_win;
      sel_s1   <= px[1:0];
      de_s1    <= i_de;
      hsync_s1 <= i_hsync;
      vsync_s1 <= i_vsync;
    end
  end

  // Stage 2 lines up with the memory's registered read data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      win_s2  <= 1'b0;
      sel_s2  <= 2'b00;
      o_de    <= 1'b0;
      o_hsync <= 1'b1;
      o_vsync <= 1'b1;
    end else begin
      win_s2  <= win_s1;
      sel_s2  <= sel_s1;
      o_de    <= de_s1;
      o_hsync <= hsync_s1;
      o_vsync <= vsync_s1;
    end
  end

  always_comb begin
    field = 2'b00;
    case (sel_s2)
      2'd0: field = i_rdata[7:6];
      2'd1: field = i_rdata[5:4];
      2'd2: field = i_rdata[3:2];
      2'd3: field = i_rdata[1:0];
      default: field = 2'b00;
    endcase
    o_color = win_s2 ? field : BG_COLOR;
  end

endmodule

// File: tb/tb_pixel_fetch.sv
// Scoreboard bench for pixel_fetch: a default instance and a 2x-scaled instance share stimulus,
// each reading its own synchronous framebuffer model.
module tb_pixel_fetch;

  localparam int AW = 13;

  typedef struct {
    logic          rd;
    logic [AW-1:0] addr;
  } exp1_t;

  typedef struct {
    logic [1:0] color;
    logic       de;
    logic       hs;
    logic       vs;
  } exp2_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          de = 1'b0;
  logic          hs = 1'b1;
  logic          vs = 1'b1;
  logic [10:0]   x = '0;
  logic [10:0]   y = '0;

  logic [AW-1:0] addr0, addr1;
  logic          rd0, rd1;
  logic [7:0]    rdata0 = '0, rdata1 = '0;
  logic [1:0]    col0, col1;
  logic          ode0, ohs0, ovs0, ode1, ohs1, ovs1;

  logic [7:0]    mem [0:8191];

  exp1_t         q1_0[$], q1_1[$];
  exp2_t         q2_0[$], q2_1[$];
  logic [AW-1:0] hold0 = '0, hold1 = '0;
  int            n_vec = 0;
  int            n_bad = 0;
  bit            chk1 = 1'b0;

  always #5 clk = ~clk;

  pixel_fetch u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_de(de), .i_hsync(hs), .i_vsync(vs),
    .i_x(x), .i_y(y), .o_addr(addr0), .o_rd_en(rd0), .i_rdata(rdata0),
    .o_color(col0), .o_de(ode0), .o_hsync(ohs0), .o_vsync(ovs0)
  );

  pixel_fetch #(.X_OFF(80), .Y_OFF(0), .SCALE_LOG2(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_de(de), .i_hsync(hs), .i_vsync(vs),
    .i_x(x), .i_y(y), .o_addr(addr1), .o_rd_en(rd1), .i_rdata(rdata1),
    .o_color(col1), .o_de(ode1), .o_hsync(ohs1), .o_vsync(ovs1)
  );

  always @(posedge clk) begin
    rdata0 <= mem[addr0];
    rdata1 <= mem[addr1];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: source row/column derived straight from display coordinates.
  task automatic model(input int xoff, input int yoff, input int s, inout logic [AW-1:0] hold,
                       output exp1_t e1, output exp2_t e2);
    int  xi, yi, px, row;
    bit  win;
    xi  = int'(x);
    yi  = int'(y);
    win = de && xi >= xoff && xi < xoff + (160 << s) && yi >= yoff && yi < yoff + (144 << s);
    e2.color = 2'b00;
    if (win) begin
      px   = (xi - xoff) >> s;
      row  = (yi - yoff) >> s;
      hold = AW'(row * 40 + px / 4);
      e2.color = 2'((mem[hold] >> (6 - 2 * (px % 4))) & 8'h03);
    end
    e1.rd   = win;
    e1.addr = hold;
    e2.de   = de;
    e2.hs   = hs;
    e2.vs   = vs;
  endtask

  task automatic step(input logic d, input logic h, input logic v, input int xi, input int yi);
    exp1_t a0, a1, c0, c1;
    exp2_t b0, b1, e0, e1;
    de = d; hs = h; vs = v; x = 11'(xi); y = 11'(yi);
    model(160, 64, 0, hold0, a0, b0);
    model(80, 0, 1, hold1, a1, b1);
    q1_0.push_back(a0); q1_1.push_back(a1);
    q2_0.push_back(b0); q2_1.push_back(b1);
    @(posedge clk); #1;
    c0 = q1_0.pop_front();
    c1 = q1_1.pop_front();
    chk("rd_en0", 32'(rd0), 32'(c0.rd));
    chk("addr0", 32'(addr0), 32'(c0.addr));
    if (chk1) begin
      chk("rd_en1", 32'(rd1), 32'(c1.rd));
      chk("addr1", 32'(addr1), 32'(c1.addr));
    end
    if (q2_0.size() >= 2) begin
      e0 = q2_0.pop_front();
      e1 = q2_1.pop_front();
      chk("color0", 32'(col0), 32'(e0.color));
      chk("de0", 32'(ode0), 32'(e0.de));
      chk("hsync0", 32'(ohs0), 32'(e0.hs));
      chk("vsync0", 32'(ovs0), 32'(e0.vs));
      if (chk1) begin
        chk("color1", 32'(col1), 32'(e1.color));
        chk("de1", 32'(ode1), 32'(e1.de));
        chk("hsync1", 32'(ohs1), 32'(e1.hs));
        chk("vsync1", 32'(ovs1), 32'(e1.vs));
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_color"}, 32'(col0), 32'd0);
    chk({tag, "_de"}, 32'(ode0), 32'd0);
    chk({tag, "_hsync"}, 32'(ohs0), 32'd1);
    chk({tag, "_vsync"}, 32'(ovs0), 32'd1);
    chk({tag, "_rd_en"}, 32'(rd0), 32'd0);
    chk({tag, "_addr"}, 32'(addr0), 32'd0);
    chk({tag, "_rd_en1"}, 32'(rd1), 32'd0);
    chk({tag, "_addr1"}, 32'(addr1), 32'd0);
  endtask

  task automatic flush();
    q1_0.delete(); q1_1.delete(); q2_0.delete(); q2_1.delete();
    hold0 = '0; hold1 = '0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    flush();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int xl[11];
    xl = '{158, 159, 160, 161, 162, 163, 316, 317, 318, 319, 320};
    for (int i = 0; i < 8192; i++) mem[i] = 8'((i * 73 + 5) ^ (i >> 5));
    mem[0] = 8'b00_01_10_11;

    #12;
    check_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Byte unpack on the first image row, then drain outside the window.
    for (int i = 160; i < 164; i++) step(1'b1, 1'b1, 1'b1, i, 64);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 0, 0);

    // Reset asserted in the middle of an active line.
    step(1'b1, 1'b1, 1'b1, 164, 64);
    step(1'b1, 1'b0, 1'b0, 165, 64);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midline");
    flush();
    @(negedge clk);
    rst_n = 1'b1;

    // Full frame scan with window-edge columns on every line.
    for (int yy = 0; yy <= 210; yy++) begin
      for (int i = 0; i < 11; i++) begin
        step(1'b1, 1'b1, 1'b1, xl[i], yy);
        if (yy == 65 && xl[i] == 160) chk("row_adv_40", 32'(addr0), 32'd40);
        if (yy == 207 && xl[i] == 319) chk("last_byte", 32'(addr0), 32'd5759);
      end
      for (int k = 0; k < 4; k++)
        step(1'b0, (k == 1 || k == 2) ? 1'b0 : 1'b1, (yy == 210) ? 1'b0 : 1'b1, 0, yy);
    end

    // 2x scaling instance from a clean reset.
    pulse_reset();
    chk1 = 1'b1;
    for (int yy = 0; yy < 4; yy++) begin
      for (int xx = 78; xx < 90; xx++) begin
        step(1'b1, 1'b1, 1'b1, xx, yy);
        if (yy == 1 && xx == 80) chk("scale_row1", 32'(addr1), 32'd0);
        if (yy == 2 && xx == 80) chk("scale_row2", 32'(addr1), 32'd40);
      end
      for (int k = 0; k < 4; k++) step(1'b0, (k == 1) ? 1'b0 : 1'b1, 1'b1, 0, yy);
    end

    // Random sync/enable patterns outside both windows, crossing a frame boundary.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 79)), (i < 150) ? 300 : 0);
    step(1'b0, 1'b1, 1'b1, 0, 0);
    step(1'b0, 1'b1, 1'b1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
